// File: rtl/mx_block_unpacker_if.sv
// Element stream bundle between the MX encoder output and the PE-array feed.
// The slave side is the unpacker; the master side drives words and accepts elements.
interface mx_block_unpacker_if #(
    parameter int BLOCK_SIZE = 32,
    parameter int ELEM_WIDTH = 6,
    parameter int EXP_WIDTH  = 8
);
    localparam int IDX_WIDTH = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [ELEM_WIDTH+1:0]   in_word;
    logic [EXP_WIDTH-1:0]    in_exp;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_sign;
    logic [ELEM_WIDTH-2:0]   out_mant;
    logic [ELEM_WIDTH-1:0]   out_value;
    logic [EXP_WIDTH-1:0]    out_exp;
    logic [IDX_WIDTH-1:0]    out_idx;
    logic                    out_first;
    logic                    out_last;

    modport master (
        output in_valid, in_word, in_exp, out_ready,
        input  in_ready, out_valid, out_sign, out_mant, out_value,
               out_exp, out_idx, out_first, out_last
    );

    modport slave (
        input  in_valid, in_word, in_exp, out_ready,
        output in_ready, out_valid, out_sign, out_mant, out_value,
               out_exp, out_idx, out_first, out_last
    );
endinterface

// File: rtl/mx_block_unpacker.sv
// Unpacks the framed MX element stream into sign/magnitude/signed-value beats
// tagged with block exponent and position, behind a single output register stage.
module mx_block_unpacker #(
    parameter int BLOCK_SIZE = 32,
    parameter int ELEM_WIDTH = 6,
    parameter int EXP_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mx_block_unpacker_if.slave   bus,
    output logic [15:0]          blk_count,
    output logic                 err,
    input  logic                 err_clr
);
    localparam int IDX_WIDTH  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int MANT_WIDTH = ELEM_WIDTH - 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(BLOCK_SIZE - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                  state;
    logic [IDX_WIDTH-1:0]    idx;
    logic [EXP_WIDTH-1:0]    exp_q;

    logic                    out_valid_q;
    logic                    out_sign_q;
    logic [MANT_WIDTH-1:0]   out_mant_q;
    logic [ELEM_WIDTH-1:0]   out_value_q;
    logic [EXP_WIDTH-1:0]    out_exp_q;
    logic [IDX_WIDTH-1:0]    out_idx_q;
    logic                    out_first_q;
    logic                    out_last_q;

    logic [1:0]              ctrl;
    logic                    elem_sign;
    logic [MANT_WIDTH-1:0]   elem_mant;
    logic [ELEM_WIDTH-1:0]   elem_value;
    logic                    in_ready_c;
    logic                    accept;
    logic [IDX_WIDTH-1:0]    next_idx;

    logic                    emit;
    logic [IDX_WIDTH-1:0]    emit_idx;
    logic                    start_blk;
    logic                    end_blk;
    logic                    frame_err;

    assign ctrl       = bus.in_word[ELEM_WIDTH+1:ELEM_WIDTH];
    assign elem_sign  = bus.in_word[ELEM_WIDTH-1];
    assign elem_mant  = bus.in_word[MANT_WIDTH-1:0];
    // Negative zero falls out as zero because -0 == 0 in two's complement.
    assign elem_value = elem_sign ? -{1'b0, elem_mant} : {1'b0, elem_mant};

    assign in_ready_c = rst_n && (!out_valid_q || bus.out_ready);
    assign accept     = bus.in_valid && in_ready_c;
    assign next_idx   = idx + IDX_WIDTH'(1);

    // Classify the accepted word: new block, continuation, or a dropped framing error.
    always_comb begin
        emit      = 1'b0;
        emit_idx  = '0;
        start_blk = 1'b0;
        end_blk   = 1'b0;
        frame_err = 1'b0;
        if (accept) begin
            if (ctrl[1]) begin
                frame_err = 1'b1;
            end else if (ctrl[0]) begin
                start_blk = 1'b1;
                emit      = 1'b1;
                frame_err = (state == ACTIVE);
            end else if (state == ACTIVE) begin
                emit      = 1'b1;
                emit_idx  = next_idx;
                end_blk   = (next_idx == LAST_IDX);
            end else begin
                frame_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            exp_q       <= '0;
            blk_count   <= '0;
            err         <= 1'b0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_mant_q  <= '0;
            out_value_q <= '0;
            out_exp_q   <= '0;
            out_idx_q   <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (emit) begin
                out_valid_q <= 1'b1;
                out_sign_q  <= elem_sign;
                out_mant_q  <= elem_mant;
                out_value_q <= elem_value;
                out_exp_q   <= start_blk ? bus.in_exp : exp_q;
                out_idx_q   <= emit_idx;
                out_first_q <= (emit_idx == '0);
                out_last_q  <= (emit_idx == LAST_IDX);
            end
            if (start_blk) begin
                exp_q <= bus.in_exp;
                idx   <= '0;
                state <= ACTIVE;
            end else if (emit) begin
                idx <= end_blk ? '0 : next_idx;
                if (end_blk) begin
                    state     <= IDLE;
                    blk_count <= blk_count + 16'd1;
                end
            end
            // A fresh framing error wins over a simultaneous clear request.
            if (frame_err) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sign  = out_sign_q;
    assign bus.out_mant  = out_mant_q;
    assign bus.out_value = out_value_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
endmodule
